btn_pulse_gen: RTL and testbench

- Transmit side of the simple button protocol. It turns PRESS/HOLD requests into a waveform on the button line that the receive-side detector classifies back as PRESS or HOLD.
- Used as a stimulus generator in Verilator benches and as an on-chip test source for the detector.
- Requests arrive over a valid/ready handshake. One waveform is generated at a time.

---
 rtl/my_pkg.sv | 23 ++
 rtl/btn_cycle_timer.sv | 28 ++
 rtl/btn_pulse_gen.sv | 132 +++++++++++++
 tb/tb_btn_pulse_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared button protocol kinds and transmit FSM states
package my_pkg;

   // Button event kinds carried on req_kind_i and kind_o; 2'b11 is not a legal kind.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRESS = 2'b01,
      HOLD  = 2'b10
   } state_e;

   // Transmit-side waveform generator states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ASSERT = 2'b01,
      S_GAP    = 2'b10
   } tx_state_e;

   // True for kinds that produce a waveform.
   function automatic logic kind_is_pulse(input state_e kind);
      return (kind == PRESS) || (kind == HOLD);
   endfunction

endpackage

// File: rtl/btn_cycle_timer.sv
// rtl/btn_cycle_timer.sv - loadable down-counter that stops at zero
module btn_cycle_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Load has priority; decrement saturates at zero so the count never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - turns PRESS/HOLD requests into timed pulses on the button line
module btn_pulse_gen
   import my_pkg::*;
#(
   parameter int PRESS_CYC = 4,
   parameter int HOLD_CYC  = 16,
   parameter int GAP_CYC   = 2,
   parameter int CNT_W     = 8
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   req_valid_i,
   output logic   req_ready_o,
   input  state_e req_kind_i,
   output logic   btn_o,
   output state_e kind_o,
   output logic   busy_o,
   output logic   done_o,
   output logic   err_o
);

   // Reject parameter sets that would break the pulse timing at elaboration.
   if ((PRESS_CYC < 1) || (HOLD_CYC <= PRESS_CYC) || (GAP_CYC < 1) ||
       ((2 ** CNT_W) <= HOLD_CYC) || ((2 ** CNT_W) <= GAP_CYC)) begin : g_param_bad
      $fatal(1, "btn_pulse_gen: illegal PRESS_CYC/HOLD_CYC/GAP_CYC/CNT_W combination");
   end

   localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);

   tx_state_e        state_q, state_d;
   state_e           kind_lat_q, kind_d;
   logic             tmr_load, tmr_dec, tmr_zero;
   logic [CNT_W-1:0] tmr_load_val;
   logic             done_d, err_d;
   logic             btn_q, done_q, err_q;
   state_e           kind_q;

   btn_cycle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Next-state, timer control and one-cycle status pulses.
   always_comb begin
      state_d      = state_q;
      kind_d       = kind_lat_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               if (req_kind_i == PRESS) begin
                  state_d      = S_ASSERT;
                  kind_d       = PRESS;
                  tmr_load     = 1'b1;
                  tmr_load_val = PRESS_LOAD;
               end else if (req_kind_i == HOLD) begin
                  state_d      = S_ASSERT;
                  kind_d       = HOLD;
                  tmr_load     = 1'b1;
                  tmr_load_val = HOLD_LOAD;
               end else begin
                  err_d = !kind_is_pulse(req_kind_i);
               end
            end
         end
         S_ASSERT: begin
            if (tmr_zero) begin
               state_d      = S_GAP;
               tmr_load     = 1'b1;
               tmr_load_val = GAP_LOAD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         S_GAP: begin
            if (tmr_zero) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register and latched kind.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         kind_lat_q <= IDLE;
      end else begin
         state_q    <= state_d;
         kind_lat_q <= kind_d;
      end
   end

   // Output flops driven from next state so btn_o and kind_o never glitch.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         btn_q  <= 1'b0;
         kind_q <= IDLE;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         btn_q  <= (state_d == S_ASSERT);
         kind_q <= (state_d == S_ASSERT) ? kind_d : IDLE;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign btn_o       = btn_q;
   assign kind_o      = kind_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - scoreboard bench for btn_pulse_gen
module tb_btn_pulse_gen;
   import my_pkg::*;

   localparam int PRESS_CYC = 4;
   localparam int HOLD_CYC  = 16;
   localparam int GAP_CYC   = 2;
   localparam int CNT_W     = 8;

   logic   clk = 1'b0;
   logic   rst_ni = 1'b0;
   logic   req_valid_i = 1'b0;
   state_e req_kind_i = IDLE;
   logic   req_ready_o, btn_o, busy_o, done_o, err_o;
   state_e kind_o;

   btn_pulse_gen #(
      .PRESS_CYC (PRESS_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .GAP_CYC   (GAP_CYC),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_kind_i  (req_kind_i),
      .btn_o       (btn_o),
      .kind_o      (kind_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic   is_err;
      state_e kind;
      int     width;
      int     rise_gap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: measures each pulse, gap and status pulse and pops the scoreboard.
   int     run = 0;
   int     gap = 0;
   int     rise_cyc = 0;
   int     last_rise = 0;
   logic   pend = 1'b0;
   state_e pkind = IDLE;
   exp_t   e;

   always @(negedge clk) begin
      if (!rst_ni) begin
         run  = 0;
         gap  = 0;
         pend = 1'b0;
      end else begin
         if (btn_o) begin
            if (run == 0) begin
               pkind    = kind_o;
               rise_cyc = cyc;
            end else if (kind_o != pkind) begin
               check("kind_stable", int'(kind_o), int'(pkind));
            end
            run++;
         end else begin
            if (run > 0) begin
               if (sb.size() == 0) begin
                  check("unexpected_pulse", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("pulse_not_err", int'(e.is_err), 0);
                  check("pulse_kind", int'(pkind), int'(e.kind));
                  check("pulse_width", run, e.width);
                  if (e.rise_gap > 0) check("rise_spacing", rise_cyc - last_rise, e.rise_gap);
               end
               last_rise = rise_cyc;
               run  = 0;
               pend = 1'b1;
               gap  = 0;
            end
            if (pend && !done_o) gap++;
         end
         if (done_o) begin
            if (!pend) begin
               check("unexpected_done", 1, 0);
            end else begin
               check("gap_len", gap, GAP_CYC);
               check("ready_at_done", int'(req_ready_o), 1);
               check("btn_at_done", int'(btn_o), 0);
            end
            pend = 1'b0;
         end
         if (err_o) begin
            if (sb.size() == 0) begin
               check("unexpected_err", 1, 0);
            end else begin
               e = sb.pop_front();
               check("err_expected", int'(e.is_err), 1);
               check("err_btn_low", int'(btn_o), 0);
               check("err_ready", int'(req_ready_o), 1);
            end
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!req_ready_o && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ready_timeout", int'(req_ready_o), 1);
   endtask

   task automatic send(input state_e k, input logic is_err, input int width);
      exp_t x;
      wait_ready();
      x.is_err   = is_err;
      x.kind     = k;
      x.width    = width;
      x.rise_gap = 0;
      sb.push_back(x);
      req_kind_i  = k;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_kind_i  = IDLE;
      if (is_err) check("ready_after_err_accept", int'(req_ready_o), 1);
      else        check("busy_after_accept", int'(busy_o), 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy_o || pend) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", sb.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_btn"},   int'(btn_o), 0);
      check({tag, "_busy"},  int'(busy_o), 0);
      check({tag, "_kind"},  int'(kind_o), int'(IDLE));
      check({tag, "_ready"}, int'(req_ready_o), 1);
      check({tag, "_done"},  int'(done_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t x;
      int   n;

      // Reset held for three cycles.
      rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      #1;
      check_idle_outputs("reset");
      check("reset_err", int'(err_o), 0);

      // Single PRESS, then single HOLD.
      send(PRESS, 1'b0, PRESS_CYC);
      drain();
      send(HOLD, 1'b0, HOLD_CYC);
      drain();

      // Back-to-back with valid held: PRESS then HOLD, kind scrambled while busy.
      wait_ready();
      x.is_err = 1'b0; x.kind = PRESS; x.width = PRESS_CYC; x.rise_gap = 0;
      sb.push_back(x);
      x.is_err = 1'b0; x.kind = HOLD; x.width = HOLD_CYC; x.rise_gap = PRESS_CYC + GAP_CYC + 1;
      sb.push_back(x);
      req_kind_i  = PRESS;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      n = 0;
      while (!req_ready_o && n < 100) begin
         req_kind_i = state_e'(n[1:0]);
         @(posedge clk);
         #1;
         n++;
      end
      check("held_valid_second_ready", int'(req_ready_o), 1);
      check("held_valid_ready_cycles", n, PRESS_CYC + GAP_CYC);
      req_kind_i = HOLD;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_kind_i  = IDLE;
      check("held_valid_busy", int'(busy_o), 1);
      drain();

      // Invalid kinds: error pulse only, no waveform, no done.
      send(IDLE, 1'b1, 0);
      send(state_e'(2'b11), 1'b1, 0);
      drain();

      // Reset in the middle of a HOLD pulse.
      wait_ready();
      req_kind_i  = HOLD;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_kind_i  = IDLE;
      repeat (7) @(posedge clk);
      #1;
      check("mid_hold_btn_high", int'(btn_o), 1);
      #2;
      rst_ni = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      #1;
      check_idle_outputs("after_reset");
      send(PRESS, 1'b0, PRESS_CYC);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
